// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: validates moves, commits them to the board, scans win lines.
// Optional LOSER_STARTS_EN: the loser (or, after a draw, the non-starter) opens the next game.
module ttt_game_ctrl #(
  parameter logic       FIRST_PLAYER = 1'b0,
  parameter logic [1:0] P1_CODE      = 2'b01,
  parameter logic [1:0] P2_CODE      = 2'b10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        enter,
  input  logic [3:0]  square_num,
  output logic [17:0] board,
  output logic        player_turn,
  output logic        busy,
  output logic        move_err,
  output logic        p1_win,
  output logic        p2_win,
  output logic        draw,
  output logic [3:0]  win_line
);

  typedef enum logic [1:0] {IDLE, PLACE, CHECK, OVER} state_t;

  state_t      state, state_nx;
  logic        enter_q;
  logic [3:0]  square_q;
  logic [3:0]  target, target_nx;
  logic [3:0]  move_cnt, move_cnt_nx;
  logic [2:0]  line_idx, line_idx_nx;
  logic [17:0] board_nx;
  logic        player_turn_nx, move_err_nx, p1_win_nx, p2_win_nx, draw_nx;
  logic [3:0]  win_line_nx;
  logic [11:0] line_sel;
  logic [1:0]  cell_a, cell_b, cell_c;
  logic        line_win;
`ifdef LOSER_STARTS_EN
  logic        start_player, start_player_nx;
  logic        restart_turn;
`endif

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] k);
    cell_of = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      if (k == i[3:0]) cell_of = b[2*i-2 +: 2];
    end
  endfunction

  function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] k,
                                           input logic [1:0] code);
    set_cell = b;
    for (int i = 1; i <= 9; i++) begin
      if (k == i[3:0]) set_cell[2*i-2 +: 2] = code;
    end
  endfunction

  // Three square numbers of each winning line, scan order rows, columns, diagonals
  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    case (idx)
      3'd0:    line_cells = {4'd1, 4'd2, 4'd3};
      3'd1:    line_cells = {4'd4, 4'd5, 4'd6};
      3'd2:    line_cells = {4'd7, 4'd8, 4'd9};
      3'd3:    line_cells = {4'd1, 4'd4, 4'd7};
      3'd4:    line_cells = {4'd2, 4'd5, 4'd8};
      3'd5:    line_cells = {4'd3, 4'd6, 4'd9};
      3'd6:    line_cells = {4'd1, 4'd5, 4'd9};
      3'd7:    line_cells = {4'd3, 4'd5, 4'd7};
      default: line_cells = {4'd1, 4'd2, 4'd3};
    endcase
  endfunction

  assign line_sel = line_cells(line_idx);
  assign cell_a   = cell_of(board, line_sel[11:8]);
  assign cell_b   = cell_of(board, line_sel[7:4]);
  assign cell_c   = cell_of(board, line_sel[3:0]);
  assign line_win = (cell_a != 2'b00) && (cell_a == cell_b) && (cell_b == cell_c);
  assign busy     = (state == PLACE) || (state == CHECK);

`ifdef LOSER_STARTS_EN
  // Opener of the next game: the loser, or after a draw the player who did not open this one
  always_comb begin
    if (p1_win)      restart_turn = 1'b1;
    else if (p2_win) restart_turn = 1'b0;
    else             restart_turn = ~start_player;
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nx       = state;
    target_nx      = target;
    move_cnt_nx    = move_cnt;
    line_idx_nx    = line_idx;
    board_nx       = board;
    player_turn_nx = player_turn;
    move_err_nx    = 1'b0;
    p1_win_nx      = p1_win;
    p2_win_nx      = p2_win;
    draw_nx        = draw;
    win_line_nx    = win_line;
`ifdef LOSER_STARTS_EN
    start_player_nx = start_player;
`endif
    case (state)
      IDLE: begin
        if (enter_q) begin
          if ((square_q >= 4'd1) && (square_q <= 4'd9) &&
              (cell_of(board, square_q) == 2'b00)) begin
            target_nx = square_q;
            state_nx  = PLACE;
          end else begin
            move_err_nx = 1'b1;
          end
        end
      end
      PLACE: begin
        board_nx    = set_cell(board, target, player_turn ? P2_CODE : P1_CODE);
        move_cnt_nx = (move_cnt >= 4'd9) ? 4'd9 : move_cnt + 4'd1;
        line_idx_nx = 3'd0;
        state_nx    = CHECK;
      end
      CHECK: begin
        if (line_win) begin
          if (cell_a == P1_CODE) p1_win_nx = 1'b1;
          else                   p2_win_nx = 1'b1;
          win_line_nx = {1'b0, line_idx} + 4'd1;
          state_nx    = OVER;
        end else if (line_idx == 3'd7) begin
          if (move_cnt == 4'd9) begin
            draw_nx  = 1'b1;
            state_nx = OVER;
          end else begin
            player_turn_nx = ~player_turn;
            state_nx       = IDLE;
          end
        end else begin
          line_idx_nx = line_idx + 3'd1;
        end
      end
      OVER: begin
        if (enter_q) begin
          board_nx    = 18'd0;
          p1_win_nx   = 1'b0;
          p2_win_nx   = 1'b0;
          draw_nx     = 1'b0;
          win_line_nx = 4'd0;
          move_cnt_nx = 4'd0;
          line_idx_nx = 3'd0;
`ifdef LOSER_STARTS_EN
          player_turn_nx  = restart_turn;
          start_player_nx = restart_turn;
`else
          player_turn_nx  = FIRST_PLAYER;
`endif
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Input capture stage and all state/output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      enter_q     <= 1'b0;
      square_q    <= 4'd0;
      state       <= IDLE;
      target      <= 4'd0;
      move_cnt    <= 4'd0;
      line_idx    <= 3'd0;
      board       <= 18'd0;
      player_turn <= FIRST_PLAYER;
      move_err    <= 1'b0;
      p1_win      <= 1'b0;
      p2_win      <= 1'b0;
      draw        <= 1'b0;
      win_line    <= 4'd0;
`ifdef LOSER_STARTS_EN
      start_player <= FIRST_PLAYER;
`endif
    end else begin
      enter_q     <= enter;
      square_q    <= square_num;
      state       <= state_nx;
      target      <= target_nx;
      move_cnt    <= move_cnt_nx;
      line_idx    <= line_idx_nx;
      board       <= board_nx;
      player_turn <= player_turn_nx;
      move_err    <= move_err_nx;
      p1_win      <= p1_win_nx;
      p2_win      <= p2_win_nx;
      draw        <= draw_nx;
      win_line    <= win_line_nx;
`ifdef LOSER_STARTS_EN
      start_player <= start_player_nx;
`endif
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed self-checking bench for ttt_game_ctrl; inputs driven and outputs sampled on negedge.
module tb_ttt_game_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        enter = 1'b0;
  logic [3:0]  square_num = 4'd0;
  logic [17:0] board;
  logic        player_turn, busy, move_err, p1_win, p2_win, draw;
  logic [3:0]  win_line;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic        exp_restart_turn;

  ttt_game_ctrl dut (
    .clk(clk), .clr(clr), .enter(enter), .square_num(square_num),
    .board(board), .player_turn(player_turn), .busy(busy), .move_err(move_err),
    .p1_win(p1_win), .p2_win(p2_win), .draw(draw), .win_line(win_line)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  // One-cycle enter pulse; returns half a cycle after the sampling edge
  task automatic press(input logic [3:0] sq);
    @(negedge clk);
    enter = 1'b1;
    square_num = sq;
    @(negedge clk);
    enter = 1'b0;
    square_num = 4'd0;
  endtask

  task automatic play(input logic [3:0] sq);
    press(sq);
    repeat (10) @(negedge clk);
  endtask

  task automatic err_try(input string tag, input logic [3:0] sq, input logic [17:0] exp_board,
                         input logic exp_turn);
    press(sq);
    chk({tag, "_err_early"}, move_err, 1'b0);
    @(negedge clk);
    chk({tag, "_err_pulse"}, move_err, 1'b1);
    @(negedge clk);
    chk({tag, "_err_gone"}, move_err, 1'b0);
    chk({tag, "_board"}, board, exp_board);
    chk({tag, "_turn"}, player_turn, exp_turn);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_board", board, 18'd0);
    chk("rst_turn", player_turn, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", move_err, 1'b0);
    chk("rst_flags", {p1_win, p2_win, draw}, 3'b000);
    chk("rst_line", win_line, 4'd0);
    clr = 1'b0;
    @(negedge clk);

    // First move on square 5: latency and busy window
    press(4'd5);
    chk("t1_busy_n0", busy, 1'b0);
    @(negedge clk);
    chk("t1_busy_n1", busy, 1'b1);
    chk("t1_board_n1", board, 18'd0);
    @(negedge clk);
    chk("t1_board_n2", board, 18'h00100);
    repeat (7) @(negedge clk);
    chk("t1_busy_n9", busy, 1'b1);
    chk("t1_turn_n9", player_turn, 1'b0);
    @(negedge clk);
    chk("t1_busy_n10", busy, 1'b0);
    chk("t1_turn_n10", player_turn, 1'b1);

    // P1 wins on top row
    do_reset();
    play(4'd1); play(4'd4); play(4'd2); play(4'd5); play(4'd3);
    chk("t2_p1win", p1_win, 1'b1);
    chk("t2_p2win", p2_win, 1'b0);
    chk("t2_line", win_line, 4'd1);
    chk("t2_turn", player_turn, 1'b0);
    chk("t2_board", board, 18'h00295);
    chk("t2_busy", busy, 1'b0);
    // Enter in OVER restarts; square 9 must not be placed
    play(4'd9);
`ifdef LOSER_STARTS_EN
    exp_restart_turn = 1'b1;
`else
    exp_restart_turn = 1'b0;
`endif
    chk("t2_rs_board", board, 18'd0);
    chk("t2_rs_flags", {p1_win, p2_win, draw}, 3'b000);
    chk("t2_rs_line", win_line, 4'd0);
    chk("t2_rs_turn", player_turn, exp_restart_turn);

    // Rejected moves
    do_reset();
    play(4'd5);
    err_try("occ", 4'd5, 18'h00100, 1'b1);
    err_try("zero", 4'd0, 18'h00100, 1'b1);
    err_try("sq12", 4'd12, 18'h00100, 1'b1);

    // Full board without a winner
    do_reset();
    play(4'd1); play(4'd2); play(4'd3); play(4'd5); play(4'd4);
    play(4'd6); play(4'd8); play(4'd7);
    chk("t4_nodraw_yet", draw, 1'b0);
    play(4'd9);
    chk("t4_draw", draw, 1'b1);
    chk("t4_wins", {p1_win, p2_win}, 2'b00);
    chk("t4_line", win_line, 4'd0);
    chk("t4_board", board, 18'h16A59);
    chk("t4_turn", player_turn, 1'b0);

    // P2 wins on anti-diagonal, then restart
    do_reset();
    play(4'd1); play(4'd3); play(4'd2); play(4'd5); play(4'd4); play(4'd7);
    chk("t5_p2win", p2_win, 1'b1);
    chk("t5_p1win", p1_win, 1'b0);
    chk("t5_line", win_line, 4'd8);
    chk("t5_turn", player_turn, 1'b1);
    play(4'd0);
    chk("t5_rs_board", board, 18'd0);
    chk("t5_rs_flags", {p1_win, p2_win, draw}, 3'b000);
    chk("t5_rs_line", win_line, 4'd0);
    chk("t5_rs_turn", player_turn, 1'b0);

    // Asynchronous clear during the 4th CHECK cycle
    do_reset();
    play(4'd1);
    press(4'd2);
    repeat (5) @(negedge clk);
    chk("t6_busy_mid", busy, 1'b1);
    clr = 1'b1;
    #1;
    chk("t6_clr_board", board, 18'd0);
    chk("t6_clr_busy", busy, 1'b0);
    chk("t6_clr_turn", player_turn, 1'b0);
    chk("t6_clr_line", win_line, 4'd0);
    @(negedge clk);
    clr = 1'b0;
    play(4'd5);
    chk("t6_again_board", board, 18'h00100);
    chk("t6_again_turn", player_turn, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
